// File: rtl/frogg_pkg.sv
// Shared types and widths for the Frogg round sequencer and its helpers.
package frogg_pkg;

  localparam int unsigned LIVES_W = 2;
  localparam int unsigned LEVEL_W = 3;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned TIME_W  = 6;
  localparam int unsigned DIV_W   = 20;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRunning  = 3'd1,
    StHit      = 3'd2,
    StWin      = 3'd3,
    StGameOver = 3'd4
  } state_e;

  // Larger divider means a slower car; each level shaves off one step.
  function automatic logic [DIV_W-1:0] car_div(input int unsigned base, input int unsigned step,
                                               input logic [LEVEL_W-1:0] level);
    return DIV_W'(base - step * 32'(level));
  endfunction

endpackage

// File: rtl/frogg_frame_timer.sv
// Frame tick from VSync falling edge plus a clearable frames-per-second divider.
module frogg_frame_timer #(
  parameter int unsigned FramesPerSec = 60
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  input  logic sec_clr_i,
  output logic frame_tick_o,
  output logic sec_tick_o
);

  localparam int unsigned SecW = (FramesPerSec > 1) ? $clog2(FramesPerSec) : 1;
  localparam logic [SecW-1:0] SecLast = SecW'(FramesPerSec - 1);

  logic            vsync_q;
  logic            tick_q;
  logic [SecW-1:0] sec_cnt_q, sec_cnt_d;

  always_comb begin
    sec_cnt_d = sec_cnt_q;
    if (sec_clr_i) begin
      sec_cnt_d = '0;
    end else if (tick_q) begin
      sec_cnt_d = (sec_cnt_q == SecLast) ? '0 : sec_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q   <= 1'b1;
      tick_q    <= 1'b0;
      sec_cnt_q <= '0;
    end else begin
      vsync_q   <= vsync_i;
      tick_q    <= vsync_q & ~vsync_i;
      sec_cnt_q <= sec_cnt_d;
    end
  end

  assign frame_tick_o = tick_q;
  assign sec_tick_o   = tick_q & ~sec_clr_i & (sec_cnt_q == SecLast);

endmodule

// File: rtl/frogg_round_ctrl.sv
// Frogg round/level sequencer: lives, score, level, countdown and car speed.
// Optional: define FROGG_BONUS_LIFE_EN to award a life every 10th win.
module frogg_round_ctrl
  import frogg_pkg::*;
#(
  parameter int unsigned c_LIVES          = 3,
  parameter int unsigned c_MAX_LEVEL      = 7,
  parameter int unsigned c_FRAMES_PER_SEC = 60,
  parameter int unsigned c_ROUND_SECS     = 30,
  parameter int unsigned c_PAUSE_FRAMES   = 60,
  parameter int unsigned c_BASE_DIV       = 100000,
  parameter int unsigned c_DIV_STEP       = 10000
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_VSync,
  input  logic               i_Game_Start,
  input  logic               i_Collision,
  input  logic               i_Frog_At_Goal,
  output logic               o_Game_Active,
  output logic               o_Frog_Reset,
  output logic [LIVES_W-1:0] o_Lives,
  output logic [LEVEL_W-1:0] o_Level,
  output logic [SCORE_W-1:0] o_Score,
  output logic [TIME_W-1:0]  o_Time_Left,
  output logic [DIV_W-1:0]   o_Car_Div,
  output logic               o_Game_Over
);

  localparam int unsigned PauseW = (c_PAUSE_FRAMES > 1) ? $clog2(c_PAUSE_FRAMES) : 1;
  localparam logic [PauseW-1:0]  PauseLast = PauseW'(c_PAUSE_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(c_LIVES);
  localparam logic [LEVEL_W-1:0] LevelMax  = LEVEL_W'(c_MAX_LEVEL);
  localparam logic [TIME_W-1:0]  TimeInit  = TIME_W'(c_ROUND_SECS);
  localparam logic [DIV_W-1:0]   DivInit   = DIV_W'(c_BASE_DIV);

  state_e             state_q;
  logic               start_q;
  logic [LIVES_W-1:0] lives_q;
  logic [LEVEL_W-1:0] level_q;
  logic [SCORE_W-1:0] score_q;
  logic [TIME_W-1:0]  time_q;
  logic [DIV_W-1:0]   div_q;
  logic [PauseW-1:0]  pause_q;
  logic               frog_rst_q;
  logic               active_q;
  logic               over_q;

  logic               frame_tick;
  logic               sec_tick;
  logic               sec_clr;
  logic               start_edge;
  logic               pause_done;
  logic [SCORE_W-1:0] score_nx;
  logic [LEVEL_W-1:0] level_nx;
  logic [LIVES_W-1:0] lives_win;

  // Second divider only runs in RUNNING, so every resume starts a fresh second.
  assign sec_clr = (state_q != StRunning);

  frogg_frame_timer #(
    .FramesPerSec(c_FRAMES_PER_SEC)
  ) u_frame_timer (
    .clk_i       (i_Clk),
    .rst_ni      (i_Rst_n),
    .vsync_i     (i_VSync),
    .sec_clr_i   (sec_clr),
    .frame_tick_o(frame_tick),
    .sec_tick_o  (sec_tick)
  );

  assign start_edge = i_Game_Start & ~start_q;
  assign pause_done = frame_tick & (pause_q == PauseLast);
  assign score_nx   = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;
  assign level_nx   = (level_q == LevelMax) ? level_q : level_q + 1'b1;

`ifdef FROGG_BONUS_LIFE_EN
  assign lives_win = (((score_nx % SCORE_W'(10)) == '0) && (lives_q != '1)) ? lives_q + 1'b1
                                                                             : lives_q;
`else
  assign lives_win = lives_q;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= StIdle;
      start_q    <= 1'b1;  // a button held through reset release is not a press
      lives_q    <= LivesInit;
      level_q    <= '0;
      score_q    <= '0;
      time_q     <= TimeInit;
      div_q      <= DivInit;
      pause_q    <= '0;
      frog_rst_q <= 1'b0;
      active_q   <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      start_q    <= i_Game_Start;
      frog_rst_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q    <= StRunning;
            frog_rst_q <= 1'b1;
            time_q     <= TimeInit;
            active_q   <= 1'b1;
          end
        end
        StRunning: begin
          if (i_Frog_At_Goal) begin
            state_q  <= StWin;
            score_q  <= score_nx;
            level_q  <= level_nx;
            div_q    <= car_div(c_BASE_DIV, c_DIV_STEP, level_nx);
            lives_q  <= lives_win;
            pause_q  <= '0;
            active_q <= 1'b0;
          end else if (i_Collision || (time_q == '0)) begin
            state_q  <= StHit;
            lives_q  <= lives_q - 1'b1;
            pause_q  <= '0;
            active_q <= 1'b0;
          end else if (sec_tick) begin
            time_q <= time_q - 1'b1;
          end
        end
        StHit, StWin: begin
          if ((state_q == StHit) && (lives_q == '0)) begin
            state_q <= StGameOver;
            over_q  <= 1'b1;
          end else if (pause_done) begin
            state_q    <= StRunning;
            frog_rst_q <= 1'b1;
            time_q     <= TimeInit;
            active_q   <= 1'b1;
          end else if (frame_tick) begin
            pause_q <= pause_q + 1'b1;
          end
        end
        StGameOver: begin
          if (start_edge) begin
            state_q    <= StRunning;
            lives_q    <= LivesInit;
            score_q    <= '0;
            level_q    <= '0;
            div_q      <= DivInit;
            time_q     <= TimeInit;
            frog_rst_q <= 1'b1;
            active_q   <= 1'b1;
            over_q     <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          active_q <= 1'b0;
          over_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_Game_Active = active_q;
  assign o_Frog_Reset  = frog_rst_q;
  assign o_Lives       = lives_q;
  assign o_Level       = level_q;
  assign o_Score       = score_q;
  assign o_Time_Left   = time_q;
  assign o_Car_Div     = div_q;
  assign o_Game_Over   = over_q;

endmodule
